dual_stack_ctrl: RTL and testbench

Command front end that sits directly upstream of the `dual_stack` block: it accepts host commands over a valid/ready channel and turns them into correctly sequenced `stack_select`/`push`/`pop`/`data_in` strobes. It guards every operation against the stack full/empty flags, returns popped data and status over a valid/ready response channel, and implements a MOVE (pop from one stack, push to the other) that the stack pair cannot perform in one cycle.

---
 rtl/dual_stack_ctrl_if.sv | 33 +++
 rtl/dual_stack_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_dual_stack_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_stack_ctrl_if.sv
// Host-side channel of dual_stack_ctrl: a command channel (valid/ready with
// opcode, stack select and push word) and a response channel (valid/ready
// with result word and reject flag).
//   master : host side, drives cmd_* payload/valid and rsp_ready
//   slave  : controller side, drives cmd_ready and rsp_* payload/valid
interface dual_stack_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();

  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_sel;
  logic [WIDTH-1:0] cmd_data;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/dual_stack_ctrl.sv
// Command front end for the dual_stack pair. Accepts one host command at a
// time, guards it against the stack full/empty flags, sequences the
// stack_select/push/pop/data_in strobes, and returns the result on the
// response channel. MOVE is split into a pop cycle and a push cycle.
//   clk, rst            : clock, synchronous active-high reset
//   host (slave)        : cmd_* in, cmd_ready out, rsp_* out, rsp_ready in
//   err_count           : saturating count of rejected commands
//   stack_select, push,
//   pop, data_in        : registered strobes to the stack pair
//   data_out            : top-of-stack word from the pair
//   s1/s2_empty/full    : stack flags from the pair
module dual_stack_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_stack_ctrl_if.slave      host,
  output logic [7:0]            err_count,
  output logic                  stack_select,
  output logic                  push,
  output logic                  pop,
  output logic [WIDTH-1:0]      data_in,
  input  logic [WIDTH-1:0]      data_out,
  input  logic                  s1_empty,
  input  logic                  s1_full,
  input  logic                  s2_empty,
  input  logic                  s2_full
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FLAGS_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MPUSH = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_STATUS = 2'b00,
    OP_PUSH   = 2'b01,
    OP_POP    = 2'b10,
    OP_MOVE   = 2'b11
  } op_t;

  // Registered state and latched command
  state_t           state_q,        state_d;
  op_t              op_q,           op_d;
  logic             sel_q,          sel_d;
  logic [WIDTH-1:0] wdata_q,        wdata_d;

  // Registered outputs
  logic             rsp_valid_q,    rsp_valid_d;
  logic             rsp_err_q,      rsp_err_d;
  logic [WIDTH-1:0] rsp_data_q,     rsp_data_d;
  logic [CNT_W-1:0] err_count_q,    err_count_d;
  logic             stack_select_q, stack_select_d;
  logic             push_q,         push_d;
  logic             pop_q,          pop_d;
  logic [WIDTH-1:0] data_in_q,      data_in_d;

  // Guard decode against the latched target/source stack
  logic             tgt_empty_c;
  logic             tgt_full_c;
  logic             dst_full_c;
  logic             reject_c;
  logic [WIDTH-1:0] status_c;

  assign tgt_empty_c = sel_q ? s2_empty : s1_empty;
  assign tgt_full_c  = sel_q ? s2_full  : s1_full;
  assign dst_full_c  = sel_q ? s1_full  : s2_full;
  assign status_c    = WIDTH'({s2_full, s2_empty, s1_full, s1_empty});

  // Reject decision made in SEL; STATUS is always accepted
  always_comb begin
    reject_c = 1'b0;
    unique case (op_q)
      OP_PUSH:   reject_c = tgt_full_c;
      OP_POP:    reject_c = tgt_empty_c;
      OP_MOVE:   reject_c = tgt_empty_c | dst_full_c;
      default:   reject_c = 1'b0;
    endcase
  end

  // Next-state and next-output logic; outputs are computed one state ahead
  // so every output port comes straight from a flop.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    sel_d          = sel_q;
    wdata_d        = wdata_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_err_d      = rsp_err_q;
    rsp_data_d     = rsp_data_q;
    err_count_d    = err_count_q;
    stack_select_d = stack_select_q;
    push_d         = 1'b0;
    pop_d          = 1'b0;
    data_in_d      = data_in_q;

    unique case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          op_d           = op_t'(host.cmd_op);
          sel_d          = host.cmd_sel;
          wdata_d        = host.cmd_data;
          stack_select_d = host.cmd_sel;
          state_d        = ST_SEL;
        end
      end

      ST_SEL: begin
        if (reject_c) begin
          if (err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_RESP;
        end else begin
          unique case (op_q)
            OP_PUSH: begin
              push_d    = 1'b1;
              data_in_d = wdata_q;
            end
            OP_POP, OP_MOVE: pop_d = 1'b1;
            default: ;
          endcase
          state_d = ST_EXEC;
        end
      end

      // data_out has been stable since SEL, so the word is taken here,
      // at the same edge the pop lands in the stack.
      ST_EXEC: begin
        rsp_err_d = 1'b0;
        unique case (op_q)
          OP_MOVE: begin
            stack_select_d = ~sel_q;
            push_d         = 1'b1;
            data_in_d      = data_out;
            state_d        = ST_MPUSH;
          end
          OP_PUSH: begin
            rsp_data_d  = wdata_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
          OP_POP: begin
            rsp_data_d  = data_out;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
          default: begin
            rsp_data_d  = status_c;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        endcase
      end

      // data_in_q still carries the moved word during the push cycle
      ST_MPUSH: begin
        rsp_data_d  = data_in_q;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_STATUS;
      sel_q          <= 1'b0;
      wdata_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= '0;
      err_count_q    <= '0;
      stack_select_q <= 1'b0;
      push_q         <= 1'b0;
      pop_q          <= 1'b0;
      data_in_q      <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      sel_q          <= sel_d;
      wdata_q        <= wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_data_q     <= rsp_data_d;
      err_count_q    <= err_count_d;
      stack_select_q <= stack_select_d;
      push_q         <= push_d;
      pop_q          <= pop_d;
      data_in_q      <= data_in_d;
    end
  end

  // Ready is an IDLE decode masked by reset, so it is low while reset is
  // held and high in the very first cycle after reset releases.
  assign host.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_err   = rsp_err_q;
  assign host.rsp_data  = rsp_data_q;
  assign err_count      = err_count_q;
  assign stack_select   = stack_select_q;
  assign push           = push_q;
  assign pop            = pop_q;
  assign data_in        = data_in_q;

  // Strobe sanity: never both, and only from EXEC or MPUSH
  a_no_push_and_pop: assert property (@(posedge clk) disable iff (rst)
    !(push_q && pop_q));
  a_strobe_state: assert property (@(posedge clk) disable iff (rst)
    (push_q || pop_q) |-> (state_q == ST_EXEC || state_q == ST_MPUSH));

endmodule

// File: tb/tb_dual_stack_ctrl.sv
// Self-checking bench for dual_stack_ctrl: a behavioural stack pair feeds the
// DUT, a transaction-level model (golden queues + timeline expectations)
// predicts every output each cycle, and a negedge process compares.
module tb_dual_stack_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_POP    = 2'b10;
  localparam logic [1:0] OP_MOVE   = 2'b11;

  typedef logic [WIDTH-1:0] word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] err_count;
  logic       stack_select, push, pop;
  word_t      data_in, data_out;
  logic       s1_empty, s1_full, s2_empty, s2_full;

  dual_stack_ctrl_if #(.WIDTH(WIDTH)) bus ();

  dual_stack_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (bus),
    .err_count    (err_count),
    .stack_select (stack_select),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .s1_empty     (s1_empty),
    .s1_full      (s1_full),
    .s2_empty     (s2_empty),
    .s2_full      (s2_full)
  );

  // Stack pair stand-in: strobes land on the rising edge, top word is shown
  // for the selected stack.
  word_t pm [2][DEPTH];
  int    pc [2];
  int    ovf = 0;
  int    unf = 0;

  assign data_out = (pc[stack_select] > 0) ? pm[stack_select][pc[stack_select]-1] : '0;
  assign s1_empty = (pc[0] == 0);
  assign s1_full  = (pc[0] == DEPTH);
  assign s2_empty = (pc[1] == 0);
  assign s2_full  = (pc[1] == DEPTH);

  always @(posedge clk) begin
    if (push === 1'b1) begin
      if (pc[stack_select] < DEPTH) begin
        pm[stack_select][pc[stack_select]] <= data_in;
        pc[stack_select] <= pc[stack_select] + 1;
      end else ovf++;
    end
    if (pop === 1'b1) begin
      if (pc[stack_select] > 0) pc[stack_select] <= pc[stack_select] - 1;
      else unf++;
    end
  end

  // Golden stacks updated per accepted command
  word_t g0[$];
  word_t g1[$];
  int    e_cnt;

  function automatic int gsize(input logic s);
    return s ? g1.size() : g0.size();
  endfunction

  function automatic word_t gtop(input logic s);
    if (s) return (g1.size() > 0) ? g1[g1.size()-1] : '0;
    return (g0.size() > 0) ? g0[g0.size()-1] : '0;
  endfunction

  task automatic gpush(input logic s, input word_t w);
    if (s) g1.push_back(w); else g0.push_back(w);
  endtask

  task automatic gpop(input logic s);
    if (s) void'(g1.pop_back()); else void'(g0.pop_back());
  endtask

  // Expected outputs for the current cycle
  bit    exp_on = 1'b0;
  logic  exp_ready, exp_push, exp_pop, exp_sel, exp_rvalid, exp_rerr;
  word_t exp_din, exp_rdata;
  logic [7:0] exp_errcnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      check("cmd_ready", bus.cmd_ready, exp_ready);
      check("push", push, exp_push);
      check("pop", pop, exp_pop);
      check("stack_select", stack_select, exp_sel);
      check("data_in", data_in, exp_din);
      check("rsp_valid", bus.rsp_valid, exp_rvalid);
      check("err_count", err_count, exp_errcnt);
      if (exp_rvalid) begin
        check("rsp_data", bus.rsp_data, exp_rdata);
        check("rsp_err", bus.rsp_err, exp_rerr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair_check();
    check("pair_depth_s1", pc[0], gsize(1'b0));
    check("pair_depth_s2", pc[1], gsize(1'b1));
    if (pc[0] > 0 && gsize(1'b0) > 0) check("pair_top_s1", pm[0][pc[0]-1], gtop(1'b0));
    if (pc[1] > 0 && gsize(1'b1) > 0) check("pair_top_s2", pm[1][pc[1]-1], gtop(1'b1));
  endtask

  // One full command: presented in the current IDLE cycle, response held
  // for 'hold' cycles before rsp_ready rises. Returns the observed response.
  task automatic run_cmd(input logic [1:0] op, input logic sel, input word_t data,
                         input int hold, output word_t rd, output logic re);
    logic  rej;
    word_t w;
    unique case (op)
      OP_PUSH: rej = (gsize(sel) == DEPTH);
      OP_POP:  rej = (gsize(sel) == 0);
      OP_MOVE: rej = (gsize(sel) == 0) || (gsize(!sel) == DEPTH);
      default: rej = 1'b0;
    endcase
    unique case (op)
      OP_PUSH: w = data;
      OP_POP, OP_MOVE: w = gtop(sel);
      default: w = WIDTH'({gsize(1'b1) == DEPTH, gsize(1'b1) == 0,
                           gsize(1'b0) == DEPTH, gsize(1'b0) == 0});
    endcase
    if (rej) w = '0;

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sel   = sel;
    bus.cmd_data  = data;
    bus.rsp_ready = 1'($urandom);
    tick();
    // Accepted; scramble the command bus, it must be ignored from now on
    bus.cmd_valid = 1'($urandom);
    bus.cmd_op    = 2'($urandom);
    bus.cmd_sel   = 1'($urandom);
    bus.cmd_data  = WIDTH'($urandom);
    exp_ready = 1'b0;
    exp_sel   = sel;
    tick();
    bus.rsp_ready = 1'($urandom);
    if (rej) begin
      if (e_cnt < 255) e_cnt++;
      exp_errcnt = 8'(e_cnt);
      exp_rvalid = 1'b1;
      exp_rdata  = '0;
      exp_rerr   = 1'b1;
    end else begin
      if (op == OP_PUSH) begin
        exp_push = 1'b1;
        exp_din  = data;
        gpush(sel, data);
      end else if (op == OP_POP || op == OP_MOVE) begin
        exp_pop = 1'b1;
        gpop(sel);
      end
      if (op == OP_MOVE) begin
        tick();
        exp_pop  = 1'b0;
        exp_push = 1'b1;
        exp_sel  = !sel;
        exp_din  = w;
        gpush(!sel, w);
      end
      tick();
      exp_push   = 1'b0;
      exp_pop    = 1'b0;
      exp_rvalid = 1'b1;
      exp_rdata  = w;
      exp_rerr   = 1'b0;
    end
    rd = bus.rsp_data;
    re = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'($urandom);
    bus.cmd_valid = 1'b0;
    exp_rvalid = 1'b0;
    exp_ready  = 1'b1;
    pair_check();
  endtask

  // MOVE from stack 1 with reset asserted during its pop cycle
  task automatic reset_mid_move();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_MOVE;
    bus.cmd_sel   = 1'b0;
    bus.cmd_data  = WIDTH'($urandom);
    tick();
    bus.cmd_valid = 1'b0;
    exp_ready = 1'b0;
    exp_sel   = 1'b0;
    tick();
    exp_pop = 1'b1;
    gpop(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pop    = 1'b0;
    exp_push   = 1'b0;
    exp_ready  = 1'b1;
    exp_sel    = 1'b0;
    exp_din    = '0;
    exp_rvalid = 1'b0;
    e_cnt      = 0;
    exp_errcnt = 8'd0;
    #1;
    check("rstmv_err_count", err_count, 8'd0);
    check("rstmv_rsp_data", bus.rsp_data, 8'h00);
    check("rstmv_rsp_err", bus.rsp_err, 1'b0);
    tick();
    check("rstmv_no_mpush", push, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t rd;
    logic  re;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_sel   = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    e_cnt = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 8'h00);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_err_count", err_count, 8'd0);
    check("rst_strobes", {push, pop, stack_select}, 3'b000);
    check("rst_data_in", data_in, 8'h00);
    rst = 1'b0;
    exp_ready = 1'b1; exp_push = 1'b0; exp_pop = 1'b0; exp_sel = 1'b0;
    exp_din = '0; exp_rvalid = 1'b0; exp_rdata = '0; exp_rerr = 1'b0;
    exp_errcnt = 8'd0;
    exp_on = 1'b1;
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

    run_cmd(OP_STATUS, 1'b0, 8'h00, 0, rd, re);
    check("status_empty_data", rd, 8'h05);
    check("status_empty_err", re, 1'b0);

    run_cmd(OP_PUSH, 1'b0, 8'hA5, 0, rd, re);
    check("push_a5_echo", rd, 8'hA5);
    check("push_a5_depth", pc[0], 1);
    run_cmd(OP_POP, 1'b0, 8'h00, 0, rd, re);
    check("pop_a5_data", rd, 8'hA5);
    check("pop_a5_err", re, 1'b0);

    run_cmd(OP_POP, 1'b1, 8'h00, 0, rd, re);
    check("pop_empty_err", re, 1'b1);
    check("pop_empty_data", rd, 8'h00);
    check("pop_empty_count", err_count, 8'd1);
    for (int i = 0; i < 259; i++) run_cmd(OP_POP, 1'b1, 8'h00, 0, rd, re);
    check("err_count_sat", err_count, 8'd255);

    run_cmd(OP_PUSH, 1'b0, 8'h3C, 0, rd, re);
    run_cmd(OP_MOVE, 1'b0, 8'h00, 0, rd, re);
    check("move_data", rd, 8'h3C);
    check("move_err", re, 1'b0);
    check("move_dst_top", pm[1][0], 8'h3C);
    check("move_src_depth", pc[0], 0);

    for (int i = 0; i < 3; i++) run_cmd(OP_PUSH, 1'b1, WIDTH'($urandom), 0, rd, re);
    run_cmd(OP_PUSH, 1'b0, 8'h11, 0, rd, re);
    run_cmd(OP_MOVE, 1'b0, 8'h00, 0, rd, re);
    check("move_full_err", re, 1'b1);
    check("move_full_data", rd, 8'h00);
    check("move_full_src_kept", pc[0], 1);

    run_cmd(OP_PUSH, 1'b0, 8'h5A, 5, rd, re);
    check("hold_push_echo", rd, 8'h5A);

    run_cmd(OP_POP, 1'b1, 8'h00, 0, rd, re);
    check("pop_s2_err", re, 1'b0);
    reset_mid_move();
    check("rstmv_src_depth", pc[0], 1);
    check("rstmv_dst_depth", pc[1], 3);
    run_cmd(OP_STATUS, 1'b0, 8'h00, 0, rd, re);
    check("status_after_rst", rd, 8'h00);

    for (int n = 0; n < 300; n++) begin
      run_cmd(2'($urandom), 1'($urandom), WIDTH'($urandom), $urandom_range(0, 3), rd, re);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        bus.cmd_op = 2'($urandom);
        tick();
      end
    end

    check("pair_overflow", ovf, 0);
    check("pair_underflow", unf, 0);
    exp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
